// File: rtl/board_mem_arbiter.sv
// Single-port arbiter for the 1024x4 game board RAM: loader > VGA > round-robin(Pac-Man, ghost).
// Optional VGA starvation guard enabled by defining BOARD_ARB_STARVE_GUARD_EN.
module board_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [ADDR_W-1:0] overwrite_addr,
  input  logic [DATA_W-1:0] initial_data,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              pac_req,
  input  logic              pac_we,
  input  logic [ADDR_W-1:0] pac_addr,
  input  logic [DATA_W-1:0] pac_wdata,
  output logic              pac_gnt,
  output logic              pac_rvalid,
  input  logic              gh_req,
  input  logic [ADDR_W-1:0] gh_addr,
  output logic              gh_gnt,
  output logic              gh_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_PAC, TAG_GH} tag_t;
  typedef enum logic {RR_PAC, RR_GH} rr_t;

  localparam int LAST = RD_LAT - 1;

  rr_t  rr_q;
  tag_t issue_tag;
  tag_t tag_q [RD_LAT];
  logic game_pend;
  logic vga_skip;

  assign game_pend = pac_req | gh_req;

`ifdef BOARD_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;
  logic       starve_force;

  // After eight straight VGA wins with a game client waiting, one arbitration goes to the game side.
  always_ff @(posedge clk) begin
    if (reset || !game_pend || pac_gnt || gh_gnt) begin
      starve_cnt   <= '0;
      starve_force <= 1'b0;
    end else if (vga_gnt) begin
      if (starve_cnt == 3'd7) begin
        starve_cnt   <= '0;
        starve_force <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

  assign vga_skip = starve_force & game_pend;
`else
  assign vga_skip = 1'b0;
`endif

  always_comb begin
    vga_gnt   = 1'b0;
    pac_gnt   = 1'b0;
    gh_gnt    = 1'b0;
    issue_tag = TAG_NONE;
    if (!reset && !hold) begin
      if (vga_req && !vga_skip) begin
        vga_gnt   = 1'b1;
        issue_tag = TAG_VGA;
      end else if (pac_req && (!gh_req || rr_q == RR_PAC)) begin
        pac_gnt   = 1'b1;
        issue_tag = pac_we ? TAG_NONE : TAG_PAC;
      end else if (gh_req) begin
        gh_gnt    = 1'b1;
        issue_tag = TAG_GH;
      end
    end
  end

  // Idle cycles keep the last address on the bus so the RAM sees no spurious toggling.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      rr_q      <= RR_PAC;
    end else begin
      busy   <= hold;
      mem_we <= 1'b0;
      if (hold) begin
        mem_we    <= 1'b1;
        mem_addr  <= overwrite_addr;
        mem_wdata <= initial_data;
      end else if (vga_gnt) begin
        mem_addr <= vga_addr;
      end else if (pac_gnt) begin
        mem_we   <= pac_we;
        mem_addr <= pac_addr;
        if (pac_we) begin
          mem_wdata <= pac_wdata;
        end
      end else if (gh_gnt) begin
        mem_addr <= gh_addr;
      end
      if (pac_gnt) begin
        rr_q <= RR_GH;
      end else if (gh_gnt) begin
        rr_q <= RR_PAC;
      end
    end
  end

  // Tags follow each read through the RAM so the returning data reaches the client that asked.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= TAG_NONE;
      end
      vga_rvalid <= 1'b0;
      pac_rvalid <= 1'b0;
      gh_rvalid  <= 1'b0;
      rdata      <= '0;
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      vga_rvalid <= (tag_q[LAST] == TAG_VGA);
      pac_rvalid <= (tag_q[LAST] == TAG_PAC);
      gh_rvalid  <= (tag_q[LAST] == TAG_GH);
      if (tag_q[LAST] != TAG_NONE) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_board_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;
  localparam int W_NONE = 0, W_VGA = 1, W_PAC = 2, W_GH = 3;

  typedef struct packed {
    logic              hold;
    logic [ADDR_W-1:0] oaddr;
    logic [DATA_W-1:0] idata;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              pac_req;
    logic              pac_we;
    logic [ADDR_W-1:0] pac_addr;
    logic [DATA_W-1:0] pac_wdata;
    logic              gh_req;
    logic [ADDR_W-1:0] gh_addr;
  } stim_t;

  typedef struct {
    int                due;
    int                who;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  stim_t cur;

  logic vga_gnt, vga_rvalid, pac_gnt, pac_rvalid, gh_gnt, gh_rvalid, mem_we, busy;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  board_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .hold(cur.hold), .overwrite_addr(cur.oaddr), .initial_data(cur.idata),
    .vga_req(cur.vga_req), .vga_addr(cur.vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .pac_req(cur.pac_req), .pac_we(cur.pac_we), .pac_addr(cur.pac_addr), .pac_wdata(cur.pac_wdata),
    .pac_gnt(pac_gnt), .pac_rvalid(pac_rvalid),
    .gh_req(cur.gh_req), .gh_addr(cur.gh_addr), .gh_gnt(gh_gnt), .gh_rvalid(gh_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] init_val(int a);
    return DATA_W'(a) ^ 4'h1;
  endfunction

  // Board RAM: address registered in the arbiter, data returned combinationally (RD_LAT = 1).
  logic [DATA_W-1:0] ram [0:1023];
  logic ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input logic r);
    @(posedge clk);
    #1;
    cur   = s;
    reset = r;
  endtask

  // Reference model: grant from priority rules, reads queued with their due cycle.
  logic [DATA_W-1:0] mram [0:1023];
  rd_t pend[$];
  int cyc = 0;
  int exp_rv = W_NONE;
  int rr_next = W_PAC;
  int streak = 0;
  logic exp_we = 1'b0, exp_busy = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0, exp_rdata = '0;

  always @(negedge clk) begin
    int who;
    logic skip;
    if (cyc == 0) for (int i = 0; i < 1024; i++) mram[i] = init_val(i);
    skip = 1'b0;
`ifdef BOARD_ARB_STARVE_GUARD_EN
    skip = (cur.pac_req || cur.gh_req) && streak >= 8;
`endif
    who = W_NONE;
    if (!reset && !cur.hold) begin
      if (cur.vga_req && !skip) who = W_VGA;
      else if (cur.pac_req && cur.gh_req) who = rr_next;
      else if (cur.pac_req) who = W_PAC;
      else if (cur.gh_req) who = W_GH;
    end
    checkOutput("vga_gnt", 32'(vga_gnt), 32'(who == W_VGA));
    checkOutput("pac_gnt", 32'(pac_gnt), 32'(who == W_PAC));
    checkOutput("gh_gnt", 32'(gh_gnt), 32'(who == W_GH));
    checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
    checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("vga_rvalid", 32'(vga_rvalid), 32'(exp_rv == W_VGA));
    checkOutput("pac_rvalid", 32'(pac_rvalid), 32'(exp_rv == W_PAC));
    checkOutput("gh_rvalid", 32'(gh_rvalid), 32'(exp_rv == W_GH));
    checkOutput("rdata", 32'(rdata), 32'(exp_rdata));

    if (reset) begin
      pend.delete();
      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_busy = 1'b0;
      exp_rv = W_NONE; exp_rdata = '0; rr_next = W_PAC; streak = 0;
    end else begin
      exp_busy = cur.hold;
      exp_rv = W_NONE;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        exp_rv = pend[0].who;
        exp_rdata = pend[0].data;
        void'(pend.pop_front());
      end
      exp_we = 1'b0;
      if (cur.hold) begin
        exp_we = 1'b1; exp_addr = cur.oaddr; exp_wdata = cur.idata;
        mram[cur.oaddr] = cur.idata;
      end else if (who == W_VGA) begin
        exp_addr = cur.vga_addr;
        pend.push_back('{cyc + 1 + RD_LAT, W_VGA, mram[cur.vga_addr]});
      end else if (who == W_PAC && cur.pac_we) begin
        exp_we = 1'b1; exp_addr = cur.pac_addr; exp_wdata = cur.pac_wdata;
        mram[cur.pac_addr] = cur.pac_wdata;
      end else if (who == W_PAC) begin
        exp_addr = cur.pac_addr;
        pend.push_back('{cyc + 1 + RD_LAT, W_PAC, mram[cur.pac_addr]});
      end else if (who == W_GH) begin
        exp_addr = cur.gh_addr;
        pend.push_back('{cyc + 1 + RD_LAT, W_GH, mram[cur.gh_addr]});
      end
      if (who == W_PAC) rr_next = W_GH;
      else if (who == W_GH) rr_next = W_PAC;
      if (who == W_PAC || who == W_GH || !(cur.pac_req || cur.gh_req)) streak = 0;
      else if (who == W_VGA) streak++;
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    cur   = '0;
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b0);

    // Loader owns the RAM; a VGA request is held off until hold drops.
    s = '0; s.hold = 1'b1; s.vga_req = 1'b1; s.vga_addr = 10'd9; s.oaddr = 10'd0; s.idata = 4'd5;
    applyStimulus(s, 1'b0);
    @(negedge clk); checkOutput("t1_vga_gnt_hold", 32'(vga_gnt), 0);
    s.oaddr = 10'd1; s.idata = 4'd6; applyStimulus(s, 1'b0);
    @(negedge clk);
    checkOutput("t1_we0", 32'(mem_we), 1); checkOutput("t1_addr0", 32'(mem_addr), 0);
    checkOutput("t1_data0", 32'(mem_wdata), 5); checkOutput("t1_busy", 32'(busy), 1);
    s.oaddr = 10'd2; s.idata = 4'd7; applyStimulus(s, 1'b0);
    @(negedge clk); checkOutput("t1_addr1", 32'(mem_addr), 1); checkOutput("t1_data1", 32'(mem_wdata), 6);
    s.hold = 1'b0; applyStimulus(s, 1'b0);
    @(negedge clk);
    checkOutput("t1_addr2", 32'(mem_addr), 2); checkOutput("t1_data2", 32'(mem_wdata), 7);
    checkOutput("t1_vga_resume", 32'(vga_gnt), 1);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t1_vga_addr", 32'(mem_addr), 9); checkOutput("t1_busy_off", 32'(busy), 0);

    // Pac-Man read of address 37 (preloaded with 4).
    s = '0; s.pac_req = 1'b1; s.pac_addr = 10'd37; applyStimulus(s, 1'b0);
    @(negedge clk); checkOutput("t2_pac_gnt", 32'(pac_gnt), 1);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t2_addr", 32'(mem_addr), 37); checkOutput("t2_we", 32'(mem_we), 0);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    checkOutput("t2_rvalid", 32'(pac_rvalid), 1); checkOutput("t2_rdata", 32'(rdata), 4);
    checkOutput("t2_gh_rvalid", 32'(gh_rvalid), 0); checkOutput("t2_vga_rvalid", 32'(vga_rvalid), 0);

    // Round-robin between Pac-Man and ghost from a fresh pointer.
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b0);
    s = '0; s.pac_req = 1'b1; s.pac_addr = 10'd50; s.gh_req = 1'b1; s.gh_addr = 10'd60;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s, 1'b0);
      @(negedge clk);
      checkOutput("t3_pac_gnt", 32'(pac_gnt), (i % 2 == 0) ? 1 : 0);
      checkOutput("t3_gh_gnt", 32'(gh_gnt), (i % 2 == 1) ? 1 : 0);
    end
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t3_pac_rv", 32'(pac_rvalid), 1); checkOutput("t3_pac_data", 32'(rdata), 3);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t3_gh_rv", 32'(gh_rvalid), 1); checkOutput("t3_gh_data", 32'(rdata), 13);

    // All three clients compete; VGA dominates unless the starvation guard steps in.
    s = '0; s.vga_req = 1'b1; s.vga_addr = 10'd500; s.pac_req = 1'b1; s.pac_addr = 10'd501;
    s.gh_req = 1'b1; s.gh_addr = 10'd502;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(s, 1'b0);
      @(negedge clk);
`ifdef BOARD_ARB_STARVE_GUARD_EN
      checkOutput("t4_vga_gnt", 32'(vga_gnt), (i == 8) ? 0 : 1);
      checkOutput("t4_pac_gnt", 32'(pac_gnt), (i == 8) ? 1 : 0);
`else
      checkOutput("t4_vga_gnt", 32'(vga_gnt), 1);
      checkOutput("t4_pac_gnt", 32'(pac_gnt), 0);
`endif
    end

    // Pac-Man clears address 100, then the ghost reads it back.
    s = '0; s.pac_req = 1'b1; s.pac_we = 1'b1; s.pac_addr = 10'd100; s.pac_wdata = 4'd0;
    applyStimulus(s, 1'b0);
    @(negedge clk); checkOutput("t5_pac_gnt", 32'(pac_gnt), 1);
    s = '0; s.gh_req = 1'b1; s.gh_addr = 10'd100; applyStimulus(s, 1'b0);
    @(negedge clk);
    checkOutput("t5_we", 32'(mem_we), 1); checkOutput("t5_addr", 32'(mem_addr), 100);
    checkOutput("t5_wdata", 32'(mem_wdata), 0); checkOutput("t5_gh_gnt", 32'(gh_gnt), 1);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t5_no_pac_rv", 32'(pac_rvalid), 0);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t5_gh_rv", 32'(gh_rvalid), 1); checkOutput("t5_rdata", 32'(rdata), 0);

    // In-flight ghost read survives hold but is flushed by reset.
    s = '0; s.gh_req = 1'b1; s.gh_addr = 10'd200; applyStimulus(s, 1'b0);
    @(negedge clk); checkOutput("t6_gh_gnt", 32'(gh_gnt), 1);
    s = '0; s.hold = 1'b1; s.oaddr = 10'd300; s.idata = 4'd9; applyStimulus(s, 1'b0);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    checkOutput("t6_gh_rv_hold", 32'(gh_rvalid), 1); checkOutput("t6_rdata", 32'(rdata), 9);
    checkOutput("t6_loader_addr", 32'(mem_addr), 300);
    s = '0; s.gh_req = 1'b1; s.gh_addr = 10'd201; applyStimulus(s, 1'b0);
    @(negedge clk); checkOutput("t6b_gh_gnt", 32'(gh_gnt), 1);
    applyStimulus('0, 1'b1);
    @(negedge clk); checkOutput("t6b_gnt_in_reset", 32'(gh_gnt), 0);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t6b_no_rv", 32'(gh_rvalid), 0); checkOutput("t6b_rdata", 32'(rdata), 0);
    applyStimulus('0, 1'b0);
    @(negedge clk); checkOutput("t6b_no_rv_late", 32'(gh_rvalid), 0);

    applyStimulus('0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Single-port arbiter for the 1024x4 game board RAM.
- Shares the RAM between four requesters:
  - board reset loader (hold / overwrite_addr / initial_data)
  - VGA tile renderer (read only)
  - Pac-Man logic (read and write, e.g. clearing eaten pellets)
  - ghost AI (read only)
- Sits between these blocks and the board RAM. Registers the single RAM command each cycle and routes read data back to the owning client.

Parameters:
- ADDR_W, 10, board RAM address width.
- DATA_W, 4, tile code width.
- RD_LAT, 1, RAM read latency in cycles from command to rdata; legal 1..3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hold  in  1  loader owns RAM, writes every cycle
- overwrite_addr  in  ADDR_W  loader write address
- initial_data  in  DATA_W  loader write data
- vga_req  in  1  renderer read request
- vga_addr  in  ADDR_W  renderer address
- vga_gnt  out  1  renderer request accepted this cycle
- vga_rvalid  out  1  renderer read data valid
- pac_req  in  1  Pac-Man request
- pac_we  in  1  Pac-Man write (1) / read (0)
- pac_addr  in  ADDR_W  Pac-Man address
- pac_wdata  in  DATA_W  Pac-Man write data
- pac_gnt  out  1  Pac-Man request accepted
- pac_rvalid  out  1  Pac-Man read data valid
- gh_req  in  1  ghost read request
- gh_addr  in  ADDR_W  ghost address
- gh_gnt  out  1  ghost request accepted
- gh_rvalid  out  1  ghost read data valid
- rdata  out  DATA_W  shared read data, qualified by *_rvalid
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  registered copy of hold

Behaviour:

Reset (sync, active-high):
- mem_we=0, mem_addr=0, mem_wdata=0.
- All gnt/rvalid=0, rdata=0, busy=0.
- Read tag pipeline flushed; round-robin pointer = PAC.
- An in-flight read at reset produces no rvalid.

Handshake:
- Client holds req/addr/we/wdata stable until gnt.
- gnt is a combinational one-cycle pulse in cycle t. The client may change or drop req in t+1.
- Requests without gnt are neither lost nor latched; the client keeps req asserted.
- Dropping req before gnt is legal and withdraws the request.

Command timing:
- Grant in cycle t registers the command at the end of t; mem_* are driven in t+1.
- For reads, rvalid of the owner and rdata are asserted in cycle t+1+RD_LAT (t+2 at default).
- A write produces no rvalid.

Priority, evaluated each cycle:
1. hold=1: no gnt. Next cycle mem_we=1, mem_addr=overwrite_addr, mem_wdata=initial_data.
2. vga_req: fixed priority over game clients, since rendering is timing critical.
3. pac_req vs gh_req: round-robin.
   - Pointer moves to the other client after either wins.
   - The lone requester always wins; the pointer is unchanged if neither is granted.

Pipeline and flow:
- Idle cycle (no grant, no hold): mem_we=0, mem_addr holds its previous value.
- One grant per cycle; back-to-back grants to the same client are allowed.
- Reads are pipelined: up to RD_LAT+1 reads can be in flight.
- The tag pipeline is RD_LAT+1 deep, 2-bit tag (NONE/VGA/PAC/GH). Exactly one rvalid per read, in grant order.

hold behaviour:
- hold rising mid-stream: the grant in that cycle is suppressed. Already-issued reads still return their rvalid with correct tags.
- Loader-write rdata is ignored (tag NONE).
- hold falling: arbitration resumes the same cycle hold=0 is seen.

Data and width rules:
- rdata = mem_rdata registered when the tag is not NONE; otherwise it holds its value.
- Addresses pass unmodified; no range checking (all 1024 locations legal).

Optional Feature:
- Macro: BOARD_ARB_STARVE_GUARD_EN.
- Enabled: a 3-bit counter counts consecutive vga grants while pac_req or gh_req is pending.
  - At 8, the next arbitration cycle skips vga and grants the round-robin game winner.
  - The counter clears on any game grant, on any cycle with no game request pending, and on reset.
- Disabled: strict vga priority. The counter is not instantiated and game clients may starve while vga_req stays high.

Test Plan:
1. Reset, then hold=1 for 3 cycles with addr 0,1,2 and data 5,6,7:
   - mem_we=1 and mem_addr/mem_wdata = 0/5, 1/6, 2/7 one cycle later.
   - All gnt=0; busy=1.
2. hold=0, RAM preloaded addr 37=4, pac_req read 37:
   - pac_gnt in cycle t.
   - mem_addr=37, mem_we=0 in t+1.
   - pac_rvalid=1, rdata=4 in t+2.
   - No other rvalid.
3. pac_req and gh_req held simultaneously for 4 cycles, pointer=PAC after reset:
   - Grants alternate pac, gh, pac, gh.
   - rvalids alternate the same way, 2 cycles later each.
4. vga_req, pac_req, gh_req all asserted:
   - vga_gnt every cycle; pac_gnt/gh_gnt stay 0 without the guard.
   - With BOARD_ARB_STARVE_GUARD_EN: pac_gnt in the 9th cycle, then vga resumes.
5. pac_req write addr 100 data 0:
   - mem_we=1, mem_addr=100, mem_wdata=0 in t+1; no pac_rvalid.
   - A following gh read of addr 100 returns rdata=0.
6. gh read granted, then hold=1 the next cycle:
   - gh_rvalid still asserted at t+2 with correct data.
   - With reset asserted at t+1 instead, gh_rvalid is never asserted.
